watchdog_reset_sequencer: RTL and testbench
===========================================

Name: watchdog_reset_sequencer

Overview:
- Sits directly downstream of the performance-monitor block and consumes its `watchdog_panic` level.
- Converts a panic into a staged recovery: a warning interrupt, then a grace countdown, then a fixed-width core reset request.
- Repeated panics are counted. After a configured number of panic resets, the block escalates to a latched fatal lockout that only a system reset clears.
- The block runs in the always-on SoC clock domain.

Parameters:
- GRACE_CYCLES, 1024: number of cycles spent in WARN before a reset is issued (must be ≥1).
- RST_PULSE, 16: number of cycles `core_rst_req` is high per panic reset (must be ≥1).
- MAX_RESETS, 3: reset count at which the block enters LOCKOUT. A value of 0 disables lockout.
- CNT_W, 8: width of the panic reset counter.

Ports:
- soc_clk  in  1  SoC clock; the single clock for the block.
- rst  in  1  Synchronous, active-high reset.
- watchdog_panic  in  1  Panic level from the perfmon block. It is synchronous to soc_clk, so no synchronizer is used.
- irq_ack  in  1  Software acknowledge; clears `panic_irq`.
- panic_irq  out  1  Warning interrupt.
- core_rst_req  out  1  Active-high core reset request.
- fatal  out  1  Lockout indicator.
- reset_count  out  CNT_W  Number of panic resets issued since `rst`; saturating.
- state  out  3  Current FSM state, for MMIO/debug readback.

Behaviour:
- Single clock domain. `rst` is synchronous and active-high.
- While `rst` is high, the following are cleared: `state`=IDLE, `panic_irq`=0, `core_rst_req`=0, `fatal`=0, `reset_count`=0, `panic_q`=0, and the countdown counter `cnt`=0.
- `rst` asserted mid-operation aborts any state on the next edge, including an in-progress reset pulse and LOCKOUT.
- Edge detect: `panic_q` is a 1-cycle registered copy of `watchdog_panic`; `rise` = `watchdog_panic` & ~`panic_q`.
  - If panic is already high when `rst` deasserts, this counts as a rise.
- All outputs are registered. State encoding: IDLE=0, WARN=1, RESET=2, HOLDOFF=3, LOCKOUT=4.
- IDLE:
  - On `rise`: go to WARN, set `cnt`=GRACE_CYCLES-1, set `panic_irq`=1.
  - A level-high panic without a rise is ignored.
- WARN:
  - If `watchdog_panic`=0 (watchdog petted): go to IDLE, clear `panic_irq`, set `cnt`=0.
    - A pet takes priority over expiry in the same cycle.
  - Else if `cnt`==0: go to RESET, set `cnt`=RST_PULSE-1, set `core_rst_req`=1, clear `panic_irq`, and increment `reset_count` (saturates at 2^CNT_W-1).
  - Else decrement `cnt`.
  - WARN lasts exactly GRACE_CYCLES cycles.
- `panic_irq`:
  - `irq_ack`=1 clears `panic_irq` in any state but does not stop the countdown.
  - Setting the IRQ in the same cycle as `irq_ack`: the set wins.
- RESET:
  - `core_rst_req` is high for exactly RST_PULSE cycles.
  - When `cnt`==0:
    - If MAX_RESETS≠0 and `reset_count`==MAX_RESETS: go to LOCKOUT.
    - Otherwise go to HOLDOFF and set `core_rst_req`=0.
  - `watchdog_panic` is ignored during RESET.
- HOLDOFF:
  - `core_rst_req`=0. Wait until `watchdog_panic`=0, then go to IDLE.
  - This prevents a reset loop while the perfmon panic remains latched.
- LOCKOUT:
  - `fatal`=1 and `core_rst_req`=1, both held.
  - Ignores all inputs except `irq_ack` (which clears `panic_irq`, already 0). Exits only via `rst`.
- Latency: a panic rising at edge N gives WARN and `panic_irq`=1 after edge N+1. `core_rst_req` rises after edge N+1+GRACE_CYCLES and falls RST_PULSE cycles later.
- `reset_count` saturation: if it is saturated and equal to MAX_RESETS, lockout still triggers. If MAX_RESETS > 2^CNT_W-1, lockout never triggers.

Test Plan:
All scenarios use GRACE_CYCLES=8, RST_PULSE=4, MAX_RESETS=2, CNT_W=8.
1. Reset: hold `rst` for 3 cycles with `watchdog_panic`=0 → all outputs 0 and `state`=0; no activity for 50 cycles.
2. Full sequence: raise `watchdog_panic` at cycle 10 and hold → `panic_irq`=1 at cycle 11; `core_rst_req` high for cycles 19–22 exactly; `reset_count`=1; `state`=3 while panic is held; drop panic → `state`=0 next cycle.
3. Pet in grace: raise panic, drop it 5 cycles later → `panic_irq`→0, `state`=0, `core_rst_req` never asserts, `reset_count`=0. Also drop panic on the exact expiry cycle → no reset.
4. IRQ ack: pulse `irq_ack` at WARN cycle 2 → `panic_irq`=0 next cycle, but `core_rst_req` still asserts on schedule. Pulse `irq_ack` on the same cycle the rise is registered → `panic_irq`=1.
5. Escalation: perform two full panic/clear cycles → after the second pulse, `state`=4, `fatal`=1, `core_rst_req` stays 1 for 100 cycles regardless of panic or `irq_ack`; assert `rst` → everything clears next edge.
6. Reset mid-pulse and held panic: assert `rst` at RESET cycle 2 → `core_rst_req`=0 next edge. Keep panic high through `rst` deassert → WARN is entered 1 cycle later (rise recognised).

Source files
------------

// File: rtl/watchdog_reset_sequencer.sv
// rtl/watchdog_reset_sequencer.sv - staged panic recovery: warn irq, grace countdown, core reset, lockout
module watchdog_reset_sequencer #(
    parameter int GRACE_CYCLES = 1024,
    parameter int RST_PULSE    = 16,
    parameter int MAX_RESETS   = 3,
    parameter int CNT_W        = 8
) (
    input  logic             soc_clk,
    input  logic             rst,
    input  logic             watchdog_panic,
    input  logic             irq_ack,
    output logic             panic_irq,
    output logic             core_rst_req,
    output logic             fatal,
    output logic [CNT_W-1:0] reset_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARN    = 3'd1,
        RESET   = 3'd2,
        HOLDOFF = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    // One down-counter serves both the grace window and the reset pulse.
    localparam int MAX_CYC = (GRACE_CYCLES > RST_PULSE) ? GRACE_CYCLES : RST_PULSE;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] GRACE_LOAD = CW'(GRACE_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(RST_PULSE - 1);
    localparam logic [31:0]   LOCK_AT    = 32'(MAX_RESETS);

    state_t        cur;
    logic          panic_q;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          lock_hit;

    assign rise  = watchdog_panic & ~panic_q;
    assign state = cur;

    // Compare at 32 bits so a MAX_RESETS beyond the counter range never matches.
    assign lock_hit = (MAX_RESETS != 0) && (32'(reset_count) == LOCK_AT);

    always_ff @(posedge soc_clk) begin
        if (rst) begin
            cur          <= IDLE;
            panic_q      <= 1'b0;
            cnt          <= '0;
            panic_irq    <= 1'b0;
            core_rst_req <= 1'b0;
            fatal        <= 1'b0;
            reset_count  <= '0;
        end else begin
            panic_q <= watchdog_panic;
            if (irq_ack) begin
                panic_irq <= 1'b0;
            end
            unique case (cur)
                IDLE: begin
                    if (rise) begin
                        cur       <= WARN;
                        cnt       <= GRACE_LOAD;
                        panic_irq <= 1'b1;
                    end
                end
                WARN: begin
                    if (!watchdog_panic) begin
                        cur       <= IDLE;
                        cnt       <= '0;
                        panic_irq <= 1'b0;
                    end else if (cnt == '0) begin
                        cur          <= RESET;
                        cnt          <= PULSE_LOAD;
                        core_rst_req <= 1'b1;
                        panic_irq    <= 1'b0;
                        if (reset_count != '1) begin
                            reset_count <= reset_count + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESET: begin
                    if (cnt == '0) begin
                        if (lock_hit) begin
                            cur   <= LOCKOUT;
                            fatal <= 1'b1;
                        end else begin
                            cur          <= HOLDOFF;
                            core_rst_req <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLDOFF: begin
                    // Stay here while the perfmon panic is still latched to avoid a reset loop.
                    if (!watchdog_panic) begin
                        cur <= IDLE;
                    end
                end
                LOCKOUT: begin
                    fatal        <= 1'b1;
                    core_rst_req <= 1'b1;
                end
                default: begin
                    cur <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_watchdog_reset_sequencer.sv
// tb/tb_watchdog_reset_sequencer.sv - self-checking bench for watchdog_reset_sequencer
module tb_watchdog_reset_sequencer;

    localparam int G     = 8;
    localparam int P     = 4;
    localparam int MAXR  = 2;
    localparam int CNT_W = 8;

    logic             soc_clk = 1'b0;
    logic             rst = 1'b1;
    logic             watchdog_panic = 1'b0;
    logic             irq_ack = 1'b0;
    logic             panic_irq;
    logic             core_rst_req;
    logic             fatal;
    logic [CNT_W-1:0] reset_count;
    logic [2:0]       state;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 1'b0;

    watchdog_reset_sequencer #(
        .GRACE_CYCLES(G),
        .RST_PULSE   (P),
        .MAX_RESETS  (MAXR),
        .CNT_W       (CNT_W)
    ) dut (
        .soc_clk       (soc_clk),
        .rst           (rst),
        .watchdog_panic(watchdog_panic),
        .irq_ack       (irq_ack),
        .panic_irq     (panic_irq),
        .core_rst_req  (core_rst_req),
        .fatal         (fatal),
        .reset_count   (reset_count),
        .state         (state)
    );

    always #5 soc_clk = ~soc_clk;

    // Model: phase plus cycles spent in it; phases last a fixed number of cycles.
    int m_phase = 0;
    int m_elapsed = 0;
    int m_count = 0;
    bit m_irq = 1'b0;
    bit m_prev = 1'b0;

    always @(posedge soc_clk) begin
        bit rise_now;
        bit set_now;
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_count = 0; m_irq = 1'b0; m_prev = 1'b0;
        end else begin
            rise_now = watchdog_panic && !m_prev;
            set_now = 1'b0;
            case (m_phase)
                0: if (rise_now) begin
                    m_phase = 1; m_elapsed = 1; m_irq = 1'b1; set_now = 1'b1;
                end
                1: if (!watchdog_panic) begin
                    m_phase = 0; m_irq = 1'b0;
                end else if (m_elapsed == G) begin
                    m_phase = 2; m_elapsed = 1; m_irq = 1'b0;
                    if (m_count < (1 << CNT_W) - 1) m_count++;
                end else begin
                    m_elapsed++;
                end
                2: if (m_elapsed == P) begin
                    m_phase = (MAXR != 0 && m_count == MAXR) ? 4 : 3;
                end else begin
                    m_elapsed++;
                end
                3: if (!watchdog_panic) m_phase = 0;
                default: ;
            endcase
            if (irq_ack && !set_now) m_irq = 1'b0;
            m_prev = watchdog_panic;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge soc_clk) begin
        if (run_cmp) begin
            chk("model_state", int'(state), m_phase);
            chk("model_irq", int'(panic_irq), int'(m_irq));
            chk("model_core_rst", int'(core_rst_req), int'(m_phase == 2 || m_phase == 4));
            chk("model_fatal", int'(fatal), int'(m_phase == 4));
            chk("model_count", int'(reset_count), m_count);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge soc_clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        step(n);
        rst = 1'b0;
    endtask

    initial begin
        // 1. reset
        step(1);
        run_cmp = 1'b1;
        step(2);
        chk("rst_state", int'(state), 0);
        chk("rst_irq", int'(panic_irq), 0);
        chk("rst_core", int'(core_rst_req), 0);
        chk("rst_fatal", int'(fatal), 0);
        chk("rst_count", int'(reset_count), 0);
        rst = 1'b0;
        step(50);
        chk("idle_50_state", int'(state), 0);

        // 2. full sequence
        watchdog_panic = 1'b1;
        step(1);
        chk("seq_irq_set", int'(panic_irq), 1);
        chk("seq_warn", int'(state), 1);
        step(7);
        chk("seq_core_before", int'(core_rst_req), 0);
        step(1);
        chk("seq_core_first", int'(core_rst_req), 1);
        chk("seq_count", int'(reset_count), 1);
        step(3);
        chk("seq_core_last", int'(core_rst_req), 1);
        step(1);
        chk("seq_core_after", int'(core_rst_req), 0);
        chk("seq_holdoff", int'(state), 3);
        step(5);
        chk("seq_holdoff_held", int'(state), 3);
        watchdog_panic = 1'b0;
        step(1);
        chk("seq_idle", int'(state), 0);

        // 3. pet in grace
        do_reset(2);
        step(2);
        watchdog_panic = 1'b1;
        step(5);
        watchdog_panic = 1'b0;
        step(1);
        chk("pet_irq", int'(panic_irq), 0);
        chk("pet_state", int'(state), 0);
        step(10);
        chk("pet_core", int'(core_rst_req), 0);
        chk("pet_count", int'(reset_count), 0);
        watchdog_panic = 1'b1;
        step(8);
        watchdog_panic = 1'b0;
        step(1);
        chk("pet_expiry_state", int'(state), 0);
        chk("pet_expiry_core", int'(core_rst_req), 0);
        step(3);
        chk("pet_expiry_count", int'(reset_count), 0);

        // 4. irq ack
        watchdog_panic = 1'b1;
        step(2);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        chk("ack_clear", int'(panic_irq), 0);
        chk("ack_still_warn", int'(state), 1);
        step(5);
        chk("ack_core_before", int'(core_rst_req), 0);
        step(1);
        chk("ack_core_on_time", int'(core_rst_req), 1);
        step(4);
        watchdog_panic = 1'b0;
        step(2);
        watchdog_panic = 1'b1;
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        chk("ack_set_wins", int'(panic_irq), 1);
        watchdog_panic = 1'b0;
        step(3);

        // 5. escalation
        do_reset(2);
        step(1);
        watchdog_panic = 1'b1;
        step(13);
        chk("esc_first_holdoff", int'(state), 3);
        watchdog_panic = 1'b0;
        step(2);
        watchdog_panic = 1'b1;
        step(13);
        chk("esc_lock_state", int'(state), 4);
        chk("esc_lock_fatal", int'(fatal), 1);
        chk("esc_lock_count", int'(reset_count), 2);
        for (int i = 0; i < 100; i++) begin
            watchdog_panic = i[2];
            irq_ack = i[3];
            step(1);
            if (i % 25 == 0) begin
                chk("esc_hold_core", int'(core_rst_req), 1);
                chk("esc_hold_fatal", int'(fatal), 1);
            end
        end
        chk("esc_end_state", int'(state), 4);
        irq_ack = 1'b0;
        watchdog_panic = 1'b0;
        do_reset(1);
        chk("esc_rst_state", int'(state), 0);
        chk("esc_rst_fatal", int'(fatal), 0);
        chk("esc_rst_core", int'(core_rst_req), 0);
        chk("esc_rst_count", int'(reset_count), 0);
        step(2);

        // 6. reset mid-pulse with held panic
        watchdog_panic = 1'b1;
        step(10);
        chk("mid_in_reset", int'(state), 2);
        rst = 1'b1;
        step(1);
        chk("mid_core_drop", int'(core_rst_req), 0);
        chk("mid_state", int'(state), 0);
        rst = 1'b0;
        step(1);
        chk("mid_rise_warn", int'(state), 1);
        chk("mid_rise_irq", int'(panic_irq), 1);
        watchdog_panic = 1'b0;
        step(3);
        chk("mid_final_idle", int'(state), 0);

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
